retire_pipe: RTL and testbench

RETIRE_PIPE -- requirements
Module: retire_pipe

---
 rtl/retire_pipe.sv | 127 ++++++++++++
 tb/tb_retire_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_pipe.sv
// Retire pipeline: carries executed ops DEPTH cycles to the regfile write port,
// merges load data one cycle after issue, and forwards in-flight results to execute.
module retire_pipe #(
  parameter int DW    = 32,
  parameter int SW    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_we,
  input  logic [SW-1:0] in_wsel,
  input  logic [DW-1:0] in_data,
  input  logic          in_ld,
  input  logic [DW-1:0] ld_data,
  input  logic [SW-1:0] asel,
  input  logic [SW-1:0] bsel,
  output logic          fwd_a_hit,
  output logic          fwd_b_hit,
  output logic [DW-1:0] fwd_a,
  output logic [DW-1:0] fwd_b,
  output logic          hazard,
  output logic          regs_we,
  output logic [SW-1:0] regs_wsel,
  output logic [DW-1:0] regs_wdata,
  output logic [31:0]   retired
);

  localparam int LAST = DEPTH - 1;

  logic          valid_reg [DEPTH];
  logic          we_reg    [DEPTH];
  logic          pend_reg  [DEPTH];
  logic [SW-1:0] wsel_reg  [DEPTH];
  logic [DW-1:0] data_reg  [DEPTH];

  logic          valid_next [DEPTH];
  logic          we_next    [DEPTH];
  logic          pend_next  [DEPTH];
  logic [SW-1:0] wsel_next  [DEPTH];
  logic [DW-1:0] data_next  [DEPTH];

  logic [31:0]   retired_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_next[gi] = in_valid;
        assign we_next[gi]    = in_we;
        assign wsel_next[gi]  = in_wsel;
        assign data_next[gi]  = in_data;
        assign pend_next[gi]  = in_valid & in_ld & in_we;
      end else if (gi == 1) begin : g_merge
        // The SRAM returns load data exactly while the load sits in S0.
        assign valid_next[gi] = valid_reg[0];
        assign we_next[gi]    = we_reg[0];
        assign wsel_next[gi]  = wsel_reg[0];
        assign data_next[gi]  = pend_reg[0] ? ld_data : data_reg[0];
        assign pend_next[gi]  = 1'b0;
      end else begin : g_copy
        assign valid_next[gi] = valid_reg[gi-1];
        assign we_next[gi]    = we_reg[gi-1];
        assign wsel_next[gi]  = wsel_reg[gi-1];
        assign data_next[gi]  = data_reg[gi-1];
        assign pend_next[gi]  = pend_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i] <= 1'b0;
        we_reg[i]    <= 1'b0;
        pend_reg[i]  <= 1'b0;
        wsel_reg[i]  <= '0;
        data_reg[i]  <= '0;
      end
      retired_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      we_reg    <= we_next;
      pend_reg  <= pend_next;
      wsel_reg  <= wsel_next;
      data_reg  <= data_next;
      if (valid_reg[LAST] && we_reg[LAST])
        retired_reg <= retired_reg + 32'd1;
    end
  end

  logic          a_match, a_pend, b_match, b_pend;
  logic [DW-1:0] a_data, b_data;

  // Oldest-to-youngest scan so the youngest matching stage overrides.
  always_comb begin
    a_match = 1'b0;
    a_pend  = 1'b0;
    a_data  = '0;
    b_match = 1'b0;
    b_pend  = 1'b0;
    b_data  = '0;
    for (int i = LAST; i >= 0; i--) begin
      if (valid_reg[i] && we_reg[i] && (wsel_reg[i] == asel)) begin
        a_match = 1'b1;
        a_pend  = pend_reg[i];
        a_data  = data_reg[i];
      end
      if (valid_reg[i] && we_reg[i] && (wsel_reg[i] == bsel)) begin
        b_match = 1'b1;
        b_pend  = pend_reg[i];
        b_data  = data_reg[i];
      end
    end
  end

  assign fwd_a_hit  = ~reset & a_match & ~a_pend;
  assign fwd_b_hit  = ~reset & b_match & ~b_pend;
  assign fwd_a      = fwd_a_hit ? a_data : '0;
  assign fwd_b      = fwd_b_hit ? b_data : '0;
  assign hazard     = ~reset & ((a_match & a_pend) | (b_match & b_pend));
  assign regs_we    = ~reset & valid_reg[LAST] & we_reg[LAST];
  assign regs_wsel  = reset ? '0 : wsel_reg[LAST];
  assign regs_wdata = reset ? '0 : data_reg[LAST];
  assign retired    = retired_reg;

endmodule

// File: tb/tb_retire_pipe.sv
// Randomized scoreboard bench for retire_pipe at DEPTH=2 and DEPTH=4 driven in lockstep;
// expected writes and forwarding results come from a history-of-ops model.
module tb_retire_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_we = 1'b0, in_ld = 1'b0;
  logic [3:0]  in_wsel = '0, asel = '0, bsel = '0;
  logic [31:0] in_data = '0, ld_data = '0;

  logic        ah2, bh2, hz2, we2, ah4, bh4, hz4, we4;
  logic [31:0] a2, b2, wd2, ret2, a4, b4, wd4, ret4;
  logic [3:0]  ws2, ws4;

  always #5 clk = ~clk;

  retire_pipe #(.DW(32), .SW(4), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .in_wsel(in_wsel),
    .in_data(in_data), .in_ld(in_ld), .ld_data(ld_data), .asel(asel), .bsel(bsel),
    .fwd_a_hit(ah2), .fwd_b_hit(bh2), .fwd_a(a2), .fwd_b(b2), .hazard(hz2),
    .regs_we(we2), .regs_wsel(ws2), .regs_wdata(wd2), .retired(ret2));

  retire_pipe #(.DW(32), .SW(4), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .in_wsel(in_wsel),
    .in_data(in_data), .in_ld(in_ld), .ld_data(ld_data), .asel(asel), .bsel(bsel),
    .fwd_a_hit(ah4), .fwd_b_hit(bh4), .fwd_a(a4), .fwd_b(b4), .hazard(hz4),
    .regs_we(we4), .regs_wsel(ws4), .regs_wdata(wd4), .retired(ret4));

  typedef struct { logic v; logic we; logic ld; logic [3:0] wsel; logic [31:0] data; } op_t;
  typedef struct { int due; logic [3:0] wsel; logic [31:0] data; } wr_t;
  typedef struct {
    logic rst; logic preset; logic haz;
    logic ah2; logic bh2; logic ah4; logic bh4;
    logic [31:0] a2; logic [31:0] b2; logic [31:0] a4; logic [31:0] b4;
  } fx_t;

  op_t  hist[$];   // hist[0] = most recently accepted op
  wr_t  wq2[$], wq4[$];
  fx_t  fq[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  logic        ld_carry = 1'b0;
  logic [31:0] ld_val = '0;
  logic [31:0] exp_ret2 = '0, exp_ret4 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Youngest in-flight writer of sel within the first depth ops wins;
  // a load still waiting for its SRAM data is a hazard, not a forward.
  task automatic model_fwd(input logic [3:0] sel, input int depth,
                           output logic hit, output logic haz, output logic [31:0] d);
    hit = 1'b0; haz = 1'b0; d = '0;
    for (int i = 0; i < depth && i < hist.size(); i++) begin
      if (hist[i].v && hist[i].we && hist[i].wsel == sel) begin
        if (i == 0 && hist[i].ld) haz = 1'b1;
        else begin hit = 1'b1; d = hist[i].data; end
        break;
      end
    end
  endtask

  task automatic step(input logic prst, input logic pv, input logic pwe, input logic pld,
                      input logic [3:0] pws, input logic [31:0] pdat, input logic [3:0] pas,
                      input logic [3:0] pbs, input logic [31:0] pldv, input logic ppre);
    fx_t fx;
    op_t op;
    logic hza, hzb, hza4, hzb4, v;
    @(posedge clk); #1;
    fx = '{default: '0};
    reset = prst; asel = pas; bsel = pbs;
    ld_data = ld_carry ? ld_val : $urandom;
    ld_carry = 1'b0;
    v = pv;
    if (prst) begin
      fx.rst = 1'b1;
      hist.delete(); wq2.delete(); wq4.delete();
    end else begin
      model_fwd(pas, 2, fx.ah2, hza, fx.a2);
      model_fwd(pbs, 2, fx.bh2, hzb, fx.b2);
      model_fwd(pas, 4, fx.ah4, hza4, fx.a4);
      model_fwd(pbs, 4, fx.bh4, hzb4, fx.b4);
      fx.haz = hza | hzb;
      if (fx.haz) v = 1'b0;
    end
    in_valid = v; in_we = pwe; in_ld = pld; in_wsel = pws; in_data = pdat;
    if (!prst) begin
      op = '{v: v, we: pwe, ld: pld, wsel: pws, data: pdat};
      if (v && pwe && pld) begin
        ld_carry = 1'b1; ld_val = pldv; op.data = pldv;
      end
      hist.push_front(op);
      if (hist.size() > 4) void'(hist.pop_back());
      if (v && pwe) begin
        wq2.push_back('{due: cyc + 2, wsel: pws, data: op.data});
        wq4.push_back('{due: cyc + 4, wsel: pws, data: op.data});
      end
    end
    if (ppre) begin
      fx.preset = 1'b1;
      force dut2.retired_reg = 32'hFFFF_FFFF;
      #1 release dut2.retired_reg;
    end
    fq.push_back(fx);
  endtask

  task automatic bubble(input logic [3:0] pas, input logic [3:0] pbs);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, pas, pbs, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] pws, input logic [31:0] pdat);
    step(1'b0, 1'b1, 1'b1, 1'b0, pws, pdat, 4'd15, 4'd15, 32'd0, 1'b0);
  endtask

  // Monitor: pops one expectation per cycle and checks the sampled outputs.
  always @(negedge clk) begin
    if (fq.size() > 0) begin
      fx_t e;
      logic ew2, ew4;
      e = fq.pop_front();
      chk("hazard2", {31'd0, hz2}, {31'd0, e.haz});
      chk("hazard4", {31'd0, hz4}, {31'd0, e.haz});
      chk("fwd_a_hit2", {31'd0, ah2}, {31'd0, e.ah2});
      chk("fwd_b_hit2", {31'd0, bh2}, {31'd0, e.bh2});
      chk("fwd_a2", a2, e.a2);
      chk("fwd_b2", b2, e.b2);
      chk("fwd_a_hit4", {31'd0, ah4}, {31'd0, e.ah4});
      chk("fwd_b_hit4", {31'd0, bh4}, {31'd0, e.bh4});
      chk("fwd_a4", a4, e.a4);
      chk("fwd_b4", b4, e.b4);
      ew2 = (wq2.size() > 0) && (wq2[0].due == cyc);
      ew4 = (wq4.size() > 0) && (wq4[0].due == cyc);
      chk("regs_we2", {31'd0, we2}, {31'd0, ew2});
      chk("regs_we4", {31'd0, we4}, {31'd0, ew4});
      if (ew2) begin
        chk("regs_wsel2", {28'd0, ws2}, {28'd0, wq2[0].wsel});
        chk("regs_wdata2", wd2, wq2[0].data);
        $display("cyc %0d depth2 write r%0d = %h", cyc, ws2, wd2);
        void'(wq2.pop_front());
      end
      if (ew4) begin
        chk("regs_wsel4", {28'd0, ws4}, {28'd0, wq4[0].wsel});
        chk("regs_wdata4", wd4, wq4[0].data);
        $display("cyc %0d depth4 write r%0d = %h", cyc, ws4, wd4);
        void'(wq4.pop_front());
      end
      if (e.rst) begin
        chk("rst_wsel2", {28'd0, ws2}, 32'd0);
        chk("rst_wdata2", wd2, 32'd0);
        chk("rst_wdata4", wd4, 32'd0);
        exp_ret2 = '0;
        exp_ret4 = '0;
      end else begin
        if (e.preset) exp_ret2 = 32'hFFFF_FFFF;
        chk("retired2", ret2, exp_ret2);
        chk("retired4", ret4, exp_ret4);
        if (ew2) exp_ret2 = exp_ret2 + 32'd1;
        if (ew4) exp_ret4 = exp_ret4 + 32'd1;
      end
    end
  end

  initial begin
    // Reset with live-looking inputs that must be discarded.
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 32'h77, 4'd7, 4'd7, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 32'h78, 4'd7, 4'd7, 32'h1, 1'b0);
    // Basic retire, then youngest-first forwarding on both ports.
    wr(4'd3, 32'h11);
    bubble(4'd3, 4'd0);
    bubble(4'd0, 4'd0);
    wr(4'd5, 32'hA);
    wr(4'd5, 32'hB);
    bubble(4'd5, 4'd5);
    // Load-use: hazard first, loaded value forwarded one cycle later.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'h100, 4'd15, 4'd15, 32'hCAFE, 1'b0);
    bubble(4'd2, 4'd9);
    bubble(4'd9, 4'd2);
    for (int i = 0; i < 4; i++) bubble(4'd0, 4'd0);
    // Bubble and non-writing op targeting r3.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h33, 4'd3, 4'd3, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'h34, 4'd3, 4'd3, 32'd0, 1'b0);
    bubble(4'd3, 4'd3);
    // Reset mid-flight, then accept an op in the first cycle after reset.
    wr(4'd6, 32'h66);
    wr(4'd8, 32'h88);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd6, 4'd8, 32'd0, 1'b0);
    wr(4'd1, 32'h1234);
    for (int i = 0; i < 5; i++) bubble(4'd1, 4'd6);
    // Counter wrap on the DEPTH=2 instance.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 32'd0, 1'b1);
    wr(4'd4, 32'h44);
    for (int i = 0; i < 5; i++) bubble(4'd4, 4'd0);
    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      logic [3:0] s_a, s_b;
      s_a = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      s_b = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 5)), $urandom, s_a, s_b, $urandom, 1'b0);
    end
    for (int i = 0; i < 6; i++) bubble(4'd0, 4'd0);
    @(negedge clk); #1;
    chk("drain", wq2.size() + wq4.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
